mux_nto1_stream: RTL and testbench

//   Parametrised N:1 stream multiplexer with a registered output stage and a valid/ready handshake.
//   Two modes: fixed-select (software picks the channel) and round-robin arbitration across all valid channels.

---
 rtl/mux_nto1_stream.sv | 97 +++++++++
 tb/tb_mux_nto1_stream.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_stream.sv
// N:1 stream mux, fixed-select or round-robin, tagging each word with its source channel index.
// Latency: 1 cycle from input transfer to out_*; sustains 1 word/cycle while out_ready stays high.
// Backpressure: output register holds while out_valid & !out_ready, and all in_ready bits are 0.
module mux_nto1_stream #(
  parameter  int N    = 8,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch
);

  logic [SELW-1:0] rr_ptr;
  logic            load_en;
  logic            rr_found;
  logic [SELW-1:0] rr_grant;
  int              rr_idx;
  logic            xfer;
  logic [SELW-1:0] xfer_ch;
  logic [W-1:0]    xfer_data;

  // Gate with rst_n so no producer sees ready while the block is held in reset.
  assign load_en = rst_n & (~out_valid | out_ready);

  // Round-robin search: first valid channel starting at rr_ptr, wrapping modulo N.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    rr_idx   = 0;
    for (int k = 0; k < N; k++) begin
      rr_idx = (int'(rr_ptr) + k) % N;
      if (!rr_found && in_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = SELW'(rr_idx);
      end
    end
  end

  // Per-channel ready: one-hot on the selected/granted channel, qualified by load_en.
  always_comb begin
    in_ready = '0;
    if (mode) begin
      if (rr_found) in_ready[rr_grant] = load_en;
    end else if (int'(sel) < N) begin
      // An out-of-range sel (possible when N is not a power of two) selects nothing.
      in_ready[sel] = load_en;
    end
  end

  // Pick the transferring channel from the one-hot handshake so the data mux never indexes out of range.
  always_comb begin
    xfer      = 1'b0;
    xfer_ch   = '0;
    xfer_data = '0;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        xfer      = 1'b1;
        xfer_ch   = SELW'(i);
        xfer_data = in_data[i*W +: W];
      end
    end
  end

  // Output register: load on transfer, drain when consumer takes the word and nothing replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= xfer_data;
      out_ch    <= xfer_ch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances past the granted channel; untouched in fixed mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (mode && xfer) begin
      rr_ptr <= (int'(xfer_ch) == N - 1) ? '0 : xfer_ch + 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench for mux_nto1_stream: table-driven fixed/round-robin vectors plus hand sequences.
// Main instance N=8, W=8; a second N=6 instance covers the out-of-range sel case.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns after the next edge.
module tb_mux_nto1_stream;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;

  logic        mode6;
  logic [2:0]  sel6;
  logic [5:0]  in_valid6;
  logic [47:0] in_data6;
  logic [5:0]  in_ready6;
  logic        out_valid6;
  logic        out_ready6;
  logic [7:0]  out_data6;
  logic [2:0]  out_ch6;

  int n_chk;
  int n_fail;

  mux_nto1_stream #(.N(8), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
  );

  mux_nto1_stream #(.N(6), .W(8)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6),
    .in_valid(in_valid6), .in_data(in_data6), .in_ready(in_ready6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6), .out_ch(out_ch6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic [7:0] vld;
    logic [7:0] exp_rdy;
    logic [2:0] exp_ch;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one transfer with out_ready=1 and check handshake and the registered result.
  task automatic apply_xfer(input string name, input logic m, input logic [2:0] s,
                            input logic [7:0] v, input logic [7:0] erdy, input logic [2:0] ech);
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = 1'b1;
    #1;
    chk({name, ".in_ready"}, 32'(in_ready), 32'(erdy));
    tick();
    chk({name, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({name, ".out_ch"}, 32'(out_ch), 32'(ech));
    chk({name, ".out_data"}, 32'(out_data), 32'(8'hA0 + 8'(ech)));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
    for (int i = 0; i < 6; i++) in_data6[i*8 +: 8] = 8'hB0 + 8'(i);
    mode6 = 1'b0; sel6 = 3'd0; in_valid6 = '0; out_ready6 = 1'b1;

    // Fixed mode sel 0..7 with every channel valid.
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b0, 3'(i), 8'hFF, 8'(1 << i), 3'(i)};
    // Round-robin with every channel valid from rr_ptr=0: 0..7,0,1.
    for (int k = 0; k < 10; k++) tbl[8 + k] = '{1'b1, 3'd0, 8'hFF, 8'(1 << (k % 8)), 3'(k % 8)};
    // One more grant (channel 2) to leave rr_ptr=3, then the sparse 7,2,7 wrap pattern.
    tbl[18] = '{1'b1, 3'd0, 8'hFF, 8'h04, 3'd2};
    tbl[19] = '{1'b1, 3'd0, 8'h84, 8'h80, 3'd7};
    tbl[20] = '{1'b1, 3'd0, 8'h84, 8'h04, 3'd2};
    tbl[21] = '{1'b1, 3'd0, 8'h84, 8'h80, 3'd7};

    // Reset state with all channels presenting data.
    rst_n = 1'b0; mode = 1'b0; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
    #3;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_ch", 32'(out_ch), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;

    for (int t = 0; t < 22; t++)
      apply_xfer($sformatf("vec%0d", t), tbl[t].mode, tbl[t].sel, tbl[t].vld, tbl[t].exp_rdy, tbl[t].exp_ch);
    // rr_ptr is now 0; output holds A7 from channel 7.

    // Backpressure: hold for 4 cycles with all channels valid.
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'd0);
      tick();
      chk($sformatf("stall%0d.out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d.out_data", c), 32'(out_data), 32'hA7);
      chk($sformatf("stall%0d.out_ch", c), 32'(out_ch), 32'd7);
    end
    // Release: held word consumed and channel 0 loaded on the same edge.
    apply_xfer("release", 1'b1, 3'd0, 8'hFF, 8'h01, 3'd0);

    // Drain: nothing valid, consumer ready -> out_valid drops, data/ch kept.
    in_valid = 8'h00;
    tick();
    chk("drain.out_valid", 32'(out_valid), 32'd0);
    chk("drain.out_data", 32'(out_data), 32'hA0);
    chk("drain.out_ch", 32'(out_ch), 32'd0);

    // Mode 1->0->1: fixed transfer on 5 must not disturb rr_ptr (1).
    apply_xfer("fix_mid", 1'b0, 3'd5, 8'hFF, 8'h20, 3'd5);
    apply_xfer("rr_resume", 1'b1, 3'd0, 8'hFF, 8'h02, 3'd1);

    // N=6 instance: sel=7 is out of range, nothing transfers.
    in_valid6 = 6'h3F; sel6 = 3'd7;
    #1;
    chk("n6_sel7.in_ready", 32'(in_ready6), 32'd0);
    tick();
    chk("n6_sel7.out_valid", 32'(out_valid6), 32'd0);
    sel6 = 3'd5;
    #1;
    chk("n6_sel5.in_ready", 32'(in_ready6), 32'h20);
    tick();
    chk("n6_sel5.out_valid", 32'(out_valid6), 32'd1);
    chk("n6_sel5.out_data", 32'(out_data6), 32'hB5);

    // Mid-operation reset between edges: word discarded at once, rr_ptr back to 0.
    chk("pre_rst.out_valid", 32'(out_valid), 32'd1);
    in_valid = 8'hFF; mode = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.out_data", 32'(out_data), 32'd0);
    chk("mid_rst.out_ch", 32'(out_ch), 32'd0);
    chk("mid_rst.in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    apply_xfer("post_rst", 1'b1, 3'd0, 8'hFF, 8'h01, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
